// File: rtl/rob_commit_unit_pkg.sv
// rtl/rob_commit_unit_pkg.sv - shared types and helpers for the ROB commit stage
package rob_commit_unit_pkg;

   localparam int unsigned VLEN          = 64;
   localparam int unsigned REG_ADDR_SIZE = 6;
   localparam int unsigned TRANS_ID_BITS = 3;

   typedef enum logic [3:0] {NONE, LOAD, STORE, ALU, CTRL_FLOW, MULT, CSR, FPU} fu_t;

   typedef enum logic [7:0] {
      ADD, SUB, XORL, LD, SD, JALR, CSRRW, MUL, FLD, FADD, FMUL, FCVT_F2I
   } fu_op;

   typedef logic [1:0] commit_state_e;
   localparam commit_state_e RUN   = 2'd0;
   localparam commit_state_e EXC   = 2'd1;
   localparam commit_state_e FLUSH = 2'd2;
   localparam commit_state_e HALT  = 2'd3;

   typedef struct packed {
      logic [63:0] cause;
      logic [63:0] tval;
      logic        valid;
   } exception_t;

   typedef struct packed {
      logic [VLEN-1:0]          pc;
      fu_t                      fu;
      fu_op                     op;
      logic [REG_ADDR_SIZE-1:0] rd;
      logic [63:0]              result;
      logic                     valid;
      exception_t               ex;
   } re_order_buffer_entry_t;

   function automatic logic is_rd_fpr(input fu_op op);
      return op inside {FLD, FADD, FMUL};
   endfunction

   // Units whose side effects must be ordered behind the ROB head, so they only retire on port 0.
   function automatic logic is_serialising(input fu_t fu);
      return fu inside {STORE, LOAD, CSR, CTRL_FLOW};
   endfunction

endpackage

// File: rtl/rob_commit_port_sel.sv
// rtl/rob_commit_port_sel.sv - per-port retire eligibility and in-order prefix chain
module rob_commit_port_sel
   import rob_commit_unit_pkg::*;
#(
   parameter int unsigned NR_COMMIT_PORTS = 2
) (
   input  logic                       i_en,
   input  logic                       i_lsu_ready,
   input  re_order_buffer_entry_t     i_entry [NR_COMMIT_PORTS],
   output logic [NR_COMMIT_PORTS-1:0] o_ack,
   output logic [NR_COMMIT_PORTS-1:0] o_we_gpr,
   output logic [NR_COMMIT_PORTS-1:0] o_we_fpr,
   output logic                       o_lsu_req,
   output logic                       o_exc
);

   logic [NR_COMMIT_PORTS-1:0] w_write;
   logic                       w_ser;
   logic                       w_unused;

   always_comb begin
      o_ack     = '0;
      o_lsu_req = 1'b0;
      o_exc     = 1'b0;
      w_write   = '0;
      if (i_en && i_entry[0].valid) begin
         if (i_entry[0].ex.valid) begin
            o_ack[0] = 1'b1;
            o_exc    = 1'b1;
         end else if (i_entry[0].fu == STORE) begin
            o_lsu_req = 1'b1;
            o_ack[0]  = i_lsu_ready;
         end else begin
            o_ack[0]   = 1'b1;
            w_write[0] = 1'b1;
         end
      end
      w_ser = is_serialising(i_entry[0].fu);
      for (int k = 1; k < NR_COMMIT_PORTS; k++) begin
         w_ser = w_ser | is_serialising(i_entry[k].fu);
         if (o_ack[k-1] && !o_exc && i_entry[k].valid && !i_entry[k].ex.valid && !w_ser) begin
            o_ack[k]   = 1'b1;
            w_write[k] = 1'b1;
         end
      end
   end

   always_comb begin
      o_we_gpr = '0;
      o_we_fpr = '0;
      for (int k = 0; k < NR_COMMIT_PORTS; k++) begin
         o_we_fpr[k] = w_write[k] & is_rd_fpr(i_entry[k].op);
         o_we_gpr[k] = w_write[k] & !is_rd_fpr(i_entry[k].op) & (i_entry[k].rd != '0);
      end
   end

   always_comb begin
      w_unused = 1'b0;
      for (int k = 0; k < NR_COMMIT_PORTS; k++) begin
         w_unused = w_unused ^ (^{i_entry[k].pc, i_entry[k].result,
                                  i_entry[k].ex.cause, i_entry[k].ex.tval});
      end
   end

endmodule

// File: rtl/rob_commit_unit.sv
// rtl/rob_commit_unit.sv - ROB commit consumer: retirement, regfile/LSU commit, exception flush
module rob_commit_unit
   import rob_commit_unit_pkg::*;
#(
   parameter int unsigned NR_COMMIT_PORTS = 2,
   parameter int unsigned INSTRET_WIDTH   = 64
) (
   input  logic                       clk_i,
   input  logic                       rst_i,
   input  logic                       halt_i,
   input  re_order_buffer_entry_t     commit_instr_i    [NR_COMMIT_PORTS],
   input  logic [TRANS_ID_BITS-1:0]   commit_trans_id_i [NR_COMMIT_PORTS],
   output logic [NR_COMMIT_PORTS-1:0] commit_ack_o,
   output logic [REG_ADDR_SIZE-1:0]   waddr_o           [NR_COMMIT_PORTS],
   output logic [63:0]                wdata_o           [NR_COMMIT_PORTS],
   output logic [NR_COMMIT_PORTS-1:0] we_gpr_o,
   output logic [NR_COMMIT_PORTS-1:0] we_fpr_o,
   output logic                       commit_lsu_o,
   input  logic                       commit_lsu_ready_i,
   output logic [TRANS_ID_BITS-1:0]   commit_tran_id_o,
   output exception_t                 exception_o,
   output logic [VLEN-1:0]            exception_pc_o,
   output logic                       flush_o,
   output logic [INSTRET_WIDTH-1:0]   instret_o
);

   commit_state_e            r_state;
   logic [63:0]              r_exc_cause;
   logic [63:0]              r_exc_tval;
   logic [VLEN-1:0]          r_exception_pc;
   logic [INSTRET_WIDTH-1:0] r_instret;
   logic [INSTRET_WIDTH-1:0] w_retired;
   logic                     w_run_en;
   logic                     w_exc;
   logic                     w_unused;

   assign w_run_en = (r_state == RUN) && !halt_i;

   rob_commit_port_sel #(.NR_COMMIT_PORTS(NR_COMMIT_PORTS)) u_port_sel (
      .i_en        (w_run_en),
      .i_lsu_ready (commit_lsu_ready_i),
      .i_entry     (commit_instr_i),
      .o_ack       (commit_ack_o),
      .o_we_gpr    (we_gpr_o),
      .o_we_fpr    (we_fpr_o),
      .o_lsu_req   (commit_lsu_o),
      .o_exc       (w_exc)
   );

   assign commit_tran_id_o = commit_trans_id_i[0];

   always_comb begin
      w_retired = '0;
      for (int k = 0; k < NR_COMMIT_PORTS; k++) begin
         waddr_o[k] = commit_instr_i[k].rd;
         wdata_o[k] = commit_instr_i[k].result;
         if (commit_ack_o[k] && !commit_instr_i[k].ex.valid) begin
            w_retired = w_retired + INSTRET_WIDTH'(1);
         end
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         r_state        <= RUN;
         r_exc_cause    <= '0;
         r_exc_tval     <= '0;
         r_exception_pc <= '0;
         r_instret      <= '0;
      end else begin
         r_instret <= r_instret + w_retired;
         case (r_state)
            RUN: begin
               if (halt_i) begin
                  r_state <= HALT;
               end else if (w_exc) begin
                  r_state        <= EXC;
                  r_exc_cause    <= commit_instr_i[0].ex.cause;
                  r_exc_tval     <= commit_instr_i[0].ex.tval;
                  r_exception_pc <= commit_instr_i[0].pc;
               end
            end
            EXC:     r_state <= FLUSH;
            FLUSH:   r_state <= RUN;
            HALT:    if (!halt_i) r_state <= RUN;
            default: r_state <= RUN;
         endcase
      end
   end

   // The report is valid only for the single EXC cycle; cause/tval/pc hold until the next exception.
   assign exception_o    = '{cause: r_exc_cause, tval: r_exc_tval, valid: (r_state == EXC)};
   assign exception_pc_o = r_exception_pc;
   assign flush_o        = (r_state == FLUSH);
   assign instret_o      = r_instret;

   always_comb begin
      w_unused = 1'b0;
      for (int k = 1; k < NR_COMMIT_PORTS; k++) begin
         w_unused = w_unused ^ (^commit_trans_id_i[k]);
      end
   end

endmodule

// File: tb/tb_rob_commit_unit.sv
// tb/tb_rob_commit_unit.sv - scoreboard bench for rob_commit_unit
module tb_rob_commit_unit;
   import rob_commit_unit_pkg::*;

   localparam int NR = 2;
   localparam int IW = 8;

   logic clk = 1'b0;
   logic rst = 1'b0;
   logic halt = 1'b0;
   logic lsu_ready = 1'b0;
   re_order_buffer_entry_t   instr [NR];
   logic [TRANS_ID_BITS-1:0] tid   [NR];
   logic [NR-1:0]            ack, we_gpr, we_fpr;
   logic [REG_ADDR_SIZE-1:0] waddr [NR];
   logic [63:0]              wdata [NR];
   logic                     lsu_req, flush;
   logic [TRANS_ID_BITS-1:0] lsu_tid;
   exception_t               exc;
   logic [VLEN-1:0]          exc_pc;
   logic [IW-1:0]            instret;

   always #5 clk = ~clk;

   rob_commit_unit #(.NR_COMMIT_PORTS(NR), .INSTRET_WIDTH(IW)) dut (
      .clk_i              (clk),
      .rst_i              (rst),
      .halt_i             (halt),
      .commit_instr_i     (instr),
      .commit_trans_id_i  (tid),
      .commit_ack_o       (ack),
      .waddr_o            (waddr),
      .wdata_o            (wdata),
      .we_gpr_o           (we_gpr),
      .we_fpr_o           (we_fpr),
      .commit_lsu_o       (lsu_req),
      .commit_lsu_ready_i (lsu_ready),
      .commit_tran_id_o   (lsu_tid),
      .exception_o        (exc),
      .exception_pc_o     (exc_pc),
      .flush_o            (flush),
      .instret_o          (instret)
   );

   typedef struct {
      logic          chk_comb;
      logic [1:0]    ack, gpr, fpr;
      logic          lsu, exc, flush;
      logic [IW-1:0] instret;
      logic          chk_exc;
      logic [63:0]   cause, pc;
      logic          chk_addr;
      logic [5:0]    a0, a1;
      logic [63:0]   d0, d1;
   } exp_t;

   exp_t          q[$];
   int            n_pass = 0;
   int            n_total = 0;
   logic [IW-1:0] m_instret;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] want);
      n_total++;
      if (act !== want) $display("FAIL %s actual=%h expected=%h", name, act, want);
      else n_pass++;
   endtask

   always @(negedge clk) begin
      exp_t e;
      if (q.size() > 0) begin
         e = q.pop_front();
         if (e.chk_comb) begin
            chk("ack", 64'(ack), 64'(e.ack));
            chk("we_gpr", 64'(we_gpr), 64'(e.gpr));
            chk("we_fpr", 64'(we_fpr), 64'(e.fpr));
            chk("commit_lsu", 64'(lsu_req), 64'(e.lsu));
            if (e.lsu) chk("commit_tran_id", 64'(lsu_tid), 64'(tid[0]));
         end
         chk("exception_valid", 64'(exc.valid), 64'(e.exc));
         chk("flush", 64'(flush), 64'(e.flush));
         chk("instret", 64'(instret), 64'(e.instret));
         if (e.chk_exc) begin
            chk("exception_cause", exc.cause, e.cause);
            chk("exception_pc", exc_pc, e.pc);
         end
         if (e.chk_addr) begin
            chk("waddr0", 64'(waddr[0]), 64'(e.a0));
            chk("waddr1", 64'(waddr[1]), 64'(e.a1));
            chk("wdata0", wdata[0], e.d0);
            chk("wdata1", wdata[1], e.d1);
         end
      end
   end

   function automatic re_order_buffer_entry_t mk(input logic v, input fu_t fu, input fu_op op,
                                                 input logic [5:0] rd, input logic [63:0] res);
      re_order_buffer_entry_t e;
      e = '0;
      e.valid = v; e.fu = fu; e.op = op; e.rd = rd; e.result = res;
      return e;
   endfunction

   function automatic exp_t ex(input logic [1:0] a, input logic [1:0] g, input logic [1:0] f,
                               input logic l, input logic x, input logic fl);
      exp_t e;
      e = '{chk_comb: 1'b1, ack: a, gpr: g, fpr: f, lsu: l, exc: x, flush: fl, instret: '0,
            chk_exc: 1'b0, cause: '0, pc: '0, chk_addr: 1'b0, a0: '0, a1: '0, d0: '0, d1: '0};
      return e;
   endfunction

   task automatic step(input re_order_buffer_entry_t e0, input re_order_buffer_entry_t e1,
                       input logic h, input logic rdy, input logic r, input exp_t e, input int retired);
      instr[0] = e0; instr[1] = e1; halt = h; lsu_ready = rdy; rst = r;
      e.instret = m_instret;
      q.push_back(e);
      @(posedge clk); #1;
      m_instret = r ? '0 : m_instret + IW'(retired);
   endtask

   initial begin
      re_order_buffer_entry_t z, al, st, x;
      exp_t e;
      z  = mk(1'b0, NONE, ADD, 6'd0, 64'h0);
      al = mk(1'b1, ALU, ADD, 6'd10, 64'h33);
      st = mk(1'b1, STORE, SD, 6'd0, 64'h0);
      x  = mk(1'b1, ALU, ADD, 6'd11, 64'h44);
      x.ex.valid = 1'b1; x.ex.cause = 64'd2; x.pc = 64'h8000_0010;
      tid[0] = 3'd5; tid[1] = 3'd6;
      instr[0] = z; instr[1] = z;
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0; m_instret = '0;

      step(z, z, 0, 0, 0, ex(2'b00, 2'b00, 2'b00, 0, 0, 0), 0);
      e = ex(2'b11, 2'b11, 2'b00, 0, 0, 0);
      e.chk_addr = 1'b1; e.a0 = 6'd5; e.a1 = 6'd6; e.d0 = 64'h11; e.d1 = 64'h22;
      step(mk(1, ALU, ADD, 6'd5, 64'h11), mk(1, ALU, ADD, 6'd6, 64'h22), 0, 0, 0, e, 2);
      step(mk(1, ALU, ADD, 6'd0, 64'h1), mk(1, ALU, SUB, 6'd7, 64'h2), 0, 0, 0,
           ex(2'b11, 2'b10, 2'b00, 0, 0, 0), 2);
      step(mk(1, FPU, FADD, 6'd3, 64'h5), mk(1, ALU, ADD, 6'd4, 64'h6), 0, 0, 0,
           ex(2'b11, 2'b10, 2'b01, 0, 0, 0), 2);
      step(mk(1, FPU, FCVT_F2I, 6'd9, 64'h7), mk(1, FPU, FMUL, 6'd2, 64'h8), 0, 0, 0,
           ex(2'b11, 2'b01, 2'b10, 0, 0, 0), 2);
      step(mk(1, LOAD, LD, 6'd8, 64'h9), mk(1, ALU, ADD, 6'd9, 64'ha), 0, 0, 0,
           ex(2'b01, 2'b01, 2'b00, 0, 0, 0), 1);
      step(al, st, 0, 1, 0, ex(2'b01, 2'b01, 2'b00, 0, 0, 0), 1);

      for (int i = 0; i < 3; i++) step(st, al, 0, 0, 0, ex(2'b00, 2'b00, 2'b00, 1, 0, 0), 0);
      step(st, al, 0, 1, 0, ex(2'b01, 2'b00, 2'b00, 1, 0, 0), 1);

      step(x, al, 0, 0, 0, ex(2'b01, 2'b00, 2'b00, 0, 0, 0), 0);
      e = ex(2'b00, 2'b00, 2'b00, 0, 1, 0);
      e.chk_exc = 1'b1; e.cause = 64'd2; e.pc = 64'h8000_0010;
      step(al, al, 1, 0, 0, e, 0);
      step(al, al, 0, 0, 0, ex(2'b00, 2'b00, 2'b00, 0, 0, 1), 0);
      step(al, al, 0, 0, 0, ex(2'b11, 2'b11, 2'b00, 0, 0, 0), 2);

      for (int i = 0; i < 5; i++) step(al, al, 1, 0, 0, ex(2'b00, 2'b00, 2'b00, 0, 0, 0), 0);
      step(al, al, 0, 0, 0, ex(2'b00, 2'b00, 2'b00, 0, 0, 0), 0);
      step(al, al, 0, 0, 0, ex(2'b11, 2'b11, 2'b00, 0, 0, 0), 2);

      for (int pass = 0; pass < 2; pass++) begin
         while (m_instret != {IW{1'b1}}) begin
            if (m_instret <= {IW{1'b1}} - IW'(2))
               step(al, al, 0, 0, 0, ex(2'b11, 2'b11, 2'b00, 0, 0, 0), 2);
            else
               step(al, z, 0, 0, 0, ex(2'b01, 2'b01, 2'b00, 0, 0, 0), 1);
         end
         if (pass == 0) begin
            step(al, z, 0, 0, 0, ex(2'b01, 2'b01, 2'b00, 0, 0, 0), 1);
         end else begin
            e = ex(2'b00, 2'b00, 2'b00, 1, 0, 0);
            e.chk_comb = 1'b0;
            step(st, z, 0, 0, 1, e, 0);
         end
         step(z, z, 0, 0, 0, ex(2'b00, 2'b00, 2'b00, 0, 0, 0), 0);
      end

      @(negedge clk); #1;
      chk("scoreboard_drained", 64'(q.size()), 64'd0);
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule

// File: doc/rob_commit_unit.md
Name: rob_commit_unit

Overview:
- Consumer end of the re-order buffer commit interface.
- Reads the NR_COMMIT_PORTS head entries the ROB presents and decides in-order retirement. Drives the per-port commit acknowledges back to the ROB.
- Drives architectural register-file writes (GPR/FPR) and store-commit requests to the LSU.
- Converts a retiring exception into a registered exception report plus a one-cycle pipeline flush.

Parameters:
- NR_COMMIT_PORTS, 2, number of ROB head slots inspected per cycle; must be ≥1.
- INSTRET_WIDTH, 64, width of the retired-instruction counter.

Ports:
- clk_i  in  1  clock
- rst_i  in  1  reset; synchronous, active-high
- halt_i  in  1  debug/WFI halt; blocks all retirement
- commit_instr_i  in  NR_COMMIT_PORTS x re_order_buffer_entry_t  ROB head entries; .valid means the result is ready
- commit_trans_id_i  in  NR_COMMIT_PORTS x TRANS_ID_BITS  ROB slot of each head entry
- commit_ack_o  out  NR_COMMIT_PORTS  retire acknowledge to the ROB
- waddr_o  out  NR_COMMIT_PORTS x REG_ADDR_SIZE  regfile write address
- wdata_o  out  NR_COMMIT_PORTS x 64  regfile write data (entry .result)
- we_gpr_o  out  NR_COMMIT_PORTS  integer regfile write enable
- we_fpr_o  out  NR_COMMIT_PORTS  FP regfile write enable
- commit_lsu_o  out  1  request to commit the head store
- commit_lsu_ready_i  in  1  LSU accepts the store this cycle
- commit_tran_id_o  out  TRANS_ID_BITS  trans id of the store being committed
- exception_o  out  exception_t  registered exception report (valid/cause/tval)
- exception_pc_o  out  VLEN  PC of the excepting instruction
- flush_o  out  1  one-cycle pipeline flush pulse
- instret_o  out  INSTRET_WIDTH  retired-instruction count

Behaviour:
- Reset (rst_i=1 at a clock edge): state=RUN, exception_o.valid=0, exception_pc_o=0, flush_o=0, instret_o=0. With the state at RUN, all acks and write enables are 0 and commit_lsu_o=0.
- FSM states: RUN, EXC, FLUSH, HALT.
- RUN:
  - If halt_i=1, the next state is HALT and no retirement happens this cycle.
  - Otherwise the retirement rules below apply.
- Port 0 retirement (combinational, same cycle):
  - Retires only if commit_instr_i[0].valid=1.
  - If ex.valid=0 and fu!=STORE: commit_ack_o[0]=1. The write enable is selected by the package function is_rd_fpr(op): we_fpr_o[0] if FPR, else we_gpr_o[0]. For GPR, rd=0 suppresses the write.
  - If fu=STORE and ex.valid=0: commit_lsu_o=1 and commit_tran_id_o=commit_trans_id_i[0]. commit_ack_o[0]=commit_lsu_ready_i. No register write.
  - If ex.valid=1: commit_ack_o[0]=1 and no write, no LSU request. The next state is EXC. exception_o and exception_pc_o latch the entry's ex and pc.
- Port k>0 retirement: retires only when all of the following hold:
  - port k-1 retires this cycle without exception;
  - entry k is valid with ex.valid=0;
  - neither entry k nor any lower entry is STORE, LOAD, CSR or CTRL_FLOW (these serialise to port 0).
  - Writes follow the same rules as port 0.
- Acks are always a contiguous prefix: commit_ack_o[k]=1 implies commit_ack_o[k-1]=1.
- EXC (one cycle): exception_o.valid=1, no acks. The next state is FLUSH.
- FLUSH (one cycle): flush_o=1, exception_o.valid=0, no acks. The next state is RUN.
- HALT: no acks, no writes, commit_lsu_o=0. When halt_i=0, the next state is RUN.
- instret:
  - Increments by the popcount of acks whose entry has ex.valid=0.
  - An excepting instruction does not count.
  - The counter wraps modulo 2^INSTRET_WIDTH.
- Simultaneous events:
  - An exception on port 0 suppresses all higher ports in the same cycle.
  - halt_i during EXC/FLUSH is ignored until RUN is re-entered.
  - rst_i overrides every state, including mid-store: commit_lsu_o drops the same cycle the state is RUN with no store pending.
- Store handshake:
  - commit_lsu_o stays asserted while the head store is valid and the LSU is not ready.
  - Acceptance is exactly one cycle with commit_lsu_o & commit_lsu_ready_i.
  - No duplicate request for the same trans id after that cycle.

Decomposition:
- Add to ariane_pkg:
  - commit_state_e (RUN/EXC/FLUSH/HALT);
  - function is_rd_fpr(fu_op);
  - function is_serialising(fu_t) covering STORE/LOAD/CSR/CTRL_FLOW.
- Reuse the existing popcount module for the instret increment.
- Reuse re_order_buffer_entry_t and exception_t unchanged.
- One natural sub-module: rob_commit_port_sel, the combinational per-port retire-eligibility and prefix chain.

Test Plan:
- Two valid ALU entries (rd=5, result=0x11; rd=6, result=0x22) → same cycle: ack=2'b11, we_gpr=2'b11, waddr={6,5}; instret 0→2.
- Port 0 ALU rd=0, port 1 ALU rd=7 → ack=2'b11, we_gpr=2'b10, instret +2.
- Head STORE, commit_lsu_ready_i=0 for 3 cycles then 1 → commit_lsu_o high 4 cycles, ack[0] only in cycle 4, ack[1]=0 throughout, instret +1.
- Port 0 ex.valid=1 cause=2, pc=0x8000_0010 → cycle 0: ack=2'b01, no write. Cycle 1: exception_o.valid=1, cause=2, exception_pc_o=0x8000_0010. Cycle 2: flush_o=1. Cycle 3: RUN. instret unchanged.
- halt_i=1 with two valid entries for 5 cycles → ack=0 for 5 cycles. Retirement resumes the cycle after halt_i=0.
- rst_i=1 asserted while a store is waiting and instret=0xFFFF_FFFF_FFFF_FFFF → next cycle: instret=0, flush_o=0, exception_o.valid=0. Separately, 1 retire from 2^64-1 wraps instret to 0.
